// File: rtl/loom_axil_pkg.sv
// Shared response codes, timeout fill pattern and FSM state encoding for the
// AXI-Lite to register-bus bridge.
package loom_axil_pkg;

   localparam logic [1:0]  RESP_OKAY     = 2'b00;
   localparam logic [1:0]  RESP_SLVERR   = 2'b10;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ACC  = 3'd1,
      ST_WR_ACC  = 3'd2,
      ST_RD_RESP = 3'd3,
      ST_WR_RESP = 3'd4
   } state_e;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb != 2'b00);
   endfunction

endpackage

// File: rtl/loom_axil_hold_reg.sv
// One-deep AXI-Lite channel holding register; ready is the registered
// complement of full, so it stays low through reset.
module loom_axil_hold_reg
   import loom_axil_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             ready_o,
   input  logic             clr_i,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_r;
   logic             ready_r;
   logic [WIDTH-1:0] data_r;
   logic             hs_s;

   assign hs_s    = valid_i & ready_r;
   assign ready_o = ready_r;
   assign full_o  = full_r;
   assign data_o  = data_r;

   // Capture on handshake, empty on grant; ready tracks !full.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_r  <= 1'b0;
         ready_r <= 1'b0;
         data_r  <= '0;
      end else if (clr_i) begin
         full_r  <= 1'b0;
         ready_r <= 1'b1;
      end else if (hs_s) begin
         full_r  <= 1'b1;
         ready_r <= 1'b0;
         data_r  <= data_i;
      end else begin
         ready_r <= ~full_r;
      end
   end

endmodule

// File: rtl/loom_axil_reg_bridge.sv
// Terminates an AXI-Lite master port and turns each read or write into a single
// outstanding register-bus access, with SLVERR on misalignment, error or timeout.
module loom_axil_reg_bridge
   import loom_axil_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
   input  logic                  s_axil_arvalid_i,
   output logic                  s_axil_arready_o,
   output logic [31:0]           s_axil_rdata_o,
   output logic [1:0]            s_axil_rresp_o,
   output logic                  s_axil_rvalid_o,
   input  logic                  s_axil_rready_i,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
   input  logic                  s_axil_awvalid_i,
   output logic                  s_axil_awready_o,
   input  logic [31:0]           s_axil_wdata_i,
   input  logic                  s_axil_wvalid_i,
   output logic                  s_axil_wready_o,
   output logic [1:0]            s_axil_bresp_o,
   output logic                  s_axil_bvalid_o,
   input  logic                  s_axil_bready_i,
   output logic                  reg_req_o,
   output logic                  reg_we_o,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic [31:0]           reg_wdata_o,
   input  logic [31:0]           reg_rdata_i,
   input  logic                  reg_error_i,
   input  logic                  reg_ready_i
);

   localparam int             CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic           TO_EN     = (TIMEOUT_CYCLES > 32'sd0);

   state_e                  state_r;
   logic                    prefer_rd_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [CNT_W-1:0]        cnt_inc_s;
   logic                    timeout_s;
   logic                    rvalid_r, bvalid_r, req_r, we_r;
   logic [31:0]             rdata_r, wdata_r;
   logic [1:0]              rresp_r, bresp_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic                    ar_full_s, aw_full_s, w_full_s;
   logic [ADDR_WIDTH-1:0]   ar_addr_s, aw_addr_s;
   logic [31:0]             w_data_s;
   logic                    rd_pend_s, wr_pend_s, contend_s;
   logic                    grant_rd_s, grant_wr_s;

   loom_axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(s_axil_arvalid_i), .data_i(s_axil_araddr_i),
      .ready_o(s_axil_arready_o), .clr_i(grant_rd_s), .full_o(ar_full_s), .data_o(ar_addr_s));

   loom_axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(s_axil_awvalid_i), .data_i(s_axil_awaddr_i),
      .ready_o(s_axil_awready_o), .clr_i(grant_wr_s), .full_o(aw_full_s), .data_o(aw_addr_s));

   loom_axil_hold_reg #(.WIDTH(32)) u_w (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(s_axil_wvalid_i), .data_i(s_axil_wdata_i),
      .ready_o(s_axil_wready_o), .clr_i(grant_wr_s), .full_o(w_full_s), .data_o(w_data_s));

   assign rd_pend_s = ar_full_s;
   assign wr_pend_s = aw_full_s & w_full_s;
   assign contend_s = rd_pend_s & wr_pend_s;
   assign cnt_inc_s = cnt_r + CNT_W'(1'b1);
   assign timeout_s = TO_EN && (cnt_inc_s == CNT_LIMIT);

   assign s_axil_rvalid_o = rvalid_r;
   assign s_axil_rdata_o  = rdata_r;
   assign s_axil_rresp_o  = rresp_r;
   assign s_axil_bvalid_o = bvalid_r;
   assign s_axil_bresp_o  = bresp_r;
   assign reg_req_o       = req_r;
   assign reg_we_o        = we_r;
   assign reg_addr_o      = addr_r;
   assign reg_wdata_o     = wdata_r;

   // Arbitration in IDLE; the round-robin pointer only decides contended grants.
   always_comb begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (rd_pend_s && (!wr_pend_s || prefer_rd_r)) begin
            grant_rd_s = 1'b1;
         end else if (wr_pend_s) begin
            grant_wr_s = 1'b1;
         end else begin
            grant_rd_s = 1'b0;
            grant_wr_s = 1'b0;
         end
      end else begin
         grant_rd_s = 1'b0;
         grant_wr_s = 1'b0;
      end
   end

   // Access sequencer: grant, register access with timeout, AXI response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         prefer_rd_r <= 1'b1;
         cnt_r       <= '0;
         rvalid_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         req_r       <= 1'b0;
         we_r        <= 1'b0;
         rdata_r     <= 32'h0000_0000;
         wdata_r     <= 32'h0000_0000;
         rresp_r     <= RESP_OKAY;
         bresp_r     <= RESP_OKAY;
         addr_r      <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_rd_s) begin
                  if (contend_s) prefer_rd_r <= 1'b0;
                  if (is_misaligned(ar_addr_s[1:0])) begin
                     state_r  <= ST_RD_RESP;
                     rvalid_r <= 1'b1;
                     rresp_r  <= RESP_SLVERR;
                     rdata_r  <= 32'h0000_0000;
                  end else begin
                     state_r <= ST_RD_ACC;
                     req_r   <= 1'b1;
                     we_r    <= 1'b0;
                     addr_r  <= ar_addr_s;
                     wdata_r <= 32'h0000_0000;
                  end
               end else if (grant_wr_s) begin
                  if (contend_s) prefer_rd_r <= 1'b1;
                  if (is_misaligned(aw_addr_s[1:0])) begin
                     state_r  <= ST_WR_RESP;
                     bvalid_r <= 1'b1;
                     bresp_r  <= RESP_SLVERR;
                  end else begin
                     state_r <= ST_WR_ACC;
                     req_r   <= 1'b1;
                     we_r    <= 1'b1;
                     addr_r  <= aw_addr_s;
                     wdata_r <= w_data_s;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RD_ACC: begin
               if (reg_ready_i || timeout_s) begin
                  state_r  <= ST_RD_RESP;
                  rvalid_r <= 1'b1;
                  rdata_r  <= reg_ready_i ? reg_rdata_i : TIMEOUT_RDATA;
                  rresp_r  <= (reg_ready_i && !reg_error_i) ? RESP_OKAY : RESP_SLVERR;
                  req_r    <= 1'b0;
                  addr_r   <= '0;
                  cnt_r    <= '0;
               end else if (TO_EN) begin
                  cnt_r <= cnt_inc_s;
               end else begin
                  cnt_r <= '0;
               end
            end
            ST_WR_ACC: begin
               if (reg_ready_i || timeout_s) begin
                  state_r  <= ST_WR_RESP;
                  bvalid_r <= 1'b1;
                  bresp_r  <= (reg_ready_i && !reg_error_i) ? RESP_OKAY : RESP_SLVERR;
                  req_r    <= 1'b0;
                  we_r     <= 1'b0;
                  addr_r   <= '0;
                  wdata_r  <= 32'h0000_0000;
                  cnt_r    <= '0;
               end else if (TO_EN) begin
                  cnt_r <= cnt_inc_s;
               end else begin
                  cnt_r <= '0;
               end
            end
            ST_RD_RESP: begin
               if (s_axil_rready_i) begin
                  state_r  <= ST_IDLE;
                  rvalid_r <= 1'b0;
                  rdata_r  <= 32'h0000_0000;
                  rresp_r  <= RESP_OKAY;
               end else begin
                  state_r <= ST_RD_RESP;
               end
            end
            ST_WR_RESP: begin
               if (s_axil_bready_i) begin
                  state_r  <= ST_IDLE;
                  bvalid_r <= 1'b0;
                  bresp_r  <= RESP_OKAY;
               end else begin
                  state_r <= ST_WR_RESP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_loom_axil_reg_bridge.sv
// Directed scoreboard bench for loom_axil_reg_bridge (TIMEOUT_CYCLES = 4).
module tb_loom_axil_reg_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [15:0] s_axil_araddr_i = 16'h0;
   logic        s_axil_arvalid_i = 1'b0;
   logic        s_axil_arready_o;
   logic [31:0] s_axil_rdata_o;
   logic [1:0]  s_axil_rresp_o;
   logic        s_axil_rvalid_o;
   logic        s_axil_rready_i = 1'b1;
   logic [15:0] s_axil_awaddr_i = 16'h0;
   logic        s_axil_awvalid_i = 1'b0;
   logic        s_axil_awready_o;
   logic [31:0] s_axil_wdata_i = 32'h0;
   logic        s_axil_wvalid_i = 1'b0;
   logic        s_axil_wready_o;
   logic [1:0]  s_axil_bresp_o;
   logic        s_axil_bvalid_o;
   logic        s_axil_bready_i = 1'b1;
   logic        reg_req_o, reg_we_o;
   logic [15:0] reg_addr_o;
   logic [31:0] reg_wdata_o;
   logic [31:0] reg_rdata_i;
   logic        reg_error_i, reg_ready_i;

   logic        auto_ready = 1'b1;
   logic        force_ready = 1'b0;
   logic [31:0] tb_rdata = 32'h0;
   logic        tb_err = 1'b0;

   assign reg_ready_i = force_ready | (auto_ready & reg_req_o);
   assign reg_rdata_i = tb_rdata;
   assign reg_error_i = tb_err;

   typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
   typedef struct { logic we; logic [15:0] addr; logic [31:0] wdata; } acc_t;
   rsp_t exp_r[$];
   rsp_t exp_b[$];
   acc_t exp_acc[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc = 0;
   int req_cycles = 0;
   int ar_hs_cyc = 0;
   int rv_rise_cyc = 0;
   logic rv_prev = 1'b0;

   loom_axil_reg_bridge #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arvalid_i(s_axil_arvalid_i),
      .s_axil_arready_o(s_axil_arready_o), .s_axil_rdata_o(s_axil_rdata_o),
      .s_axil_rresp_o(s_axil_rresp_o), .s_axil_rvalid_o(s_axil_rvalid_o),
      .s_axil_rready_i(s_axil_rready_i), .s_axil_awaddr_i(s_axil_awaddr_i),
      .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
      .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wvalid_i(s_axil_wvalid_i),
      .s_axil_wready_o(s_axil_wready_o), .s_axil_bresp_o(s_axil_bresp_o),
      .s_axil_bvalid_o(s_axil_bvalid_o), .s_axil_bready_i(s_axil_bready_i),
      .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
      .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
      .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks = n_checks + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // Output monitor: pops the scoreboard on register accesses and AXI responses.
   always @(negedge clk_i) begin
      acc_t ea;
      rsp_t er;
      if (!rst_i) begin
         if (reg_req_o) req_cycles = req_cycles + 1;
         if (s_axil_arvalid_i && s_axil_arready_o) ar_hs_cyc = cyc;
         if (s_axil_rvalid_o && !rv_prev) rv_rise_cyc = cyc;
         if (reg_req_o && reg_ready_i) begin
            if (exp_acc.size() == 0) begin
               check("acc_unexpected", 32'(exp_acc.size()), 32'd1);
            end else begin
               ea = exp_acc.pop_front();
               check("acc_we", {31'd0, reg_we_o}, {31'd0, ea.we});
               check("acc_addr", {16'd0, reg_addr_o}, {16'd0, ea.addr});
               if (ea.we) check("acc_wdata", reg_wdata_o, ea.wdata);
            end
         end
         if (s_axil_rvalid_o && s_axil_rready_i) begin
            if (exp_r.size() == 0) begin
               check("r_unexpected", 32'(exp_r.size()), 32'd1);
            end else begin
               er = exp_r.pop_front();
               check("rdata", s_axil_rdata_o, er.data);
               check("rresp", {30'd0, s_axil_rresp_o}, {30'd0, er.resp});
            end
         end
         if (s_axil_bvalid_o && s_axil_bready_i) begin
            if (exp_b.size() == 0) begin
               check("b_unexpected", 32'(exp_b.size()), 32'd1);
            end else begin
               er = exp_b.pop_front();
               check("bresp", {30'd0, s_axil_bresp_o}, {30'd0, er.resp});
            end
         end
      end
      rv_prev = s_axil_rvalid_o;
   end

   task automatic drive(input logic do_ar, input logic [15:0] ara, input logic do_aw,
                        input logic [15:0] awa, input logic do_w, input logic [31:0] wd);
      logic ar_p, aw_p, w_p, ar_h, aw_h, w_h;
      int n;
      s_axil_araddr_i = ara; s_axil_awaddr_i = awa; s_axil_wdata_i = wd;
      s_axil_arvalid_i = do_ar; s_axil_awvalid_i = do_aw; s_axil_wvalid_i = do_w;
      ar_p = do_ar; aw_p = do_aw; w_p = do_w; n = 0;
      while ((ar_p || aw_p || w_p) && n < 50) begin
         @(negedge clk_i);
         ar_h = ar_p & s_axil_arready_o;
         aw_h = aw_p & s_axil_awready_o;
         w_h  = w_p & s_axil_wready_o;
         @(posedge clk_i); #1;
         if (ar_h) begin s_axil_arvalid_i = 1'b0; ar_p = 1'b0; end
         if (aw_h) begin s_axil_awvalid_i = 1'b0; aw_p = 1'b0; end
         if (w_h)  begin s_axil_wvalid_i  = 1'b0; w_p  = 1'b0; end
         n = n + 1;
      end
      check("drive_handshake", {29'd0, ar_p, aw_p, w_p}, 32'd0);
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while ((exp_r.size() + exp_b.size() + exp_acc.size()) != 0 && n < 200) begin
         @(posedge clk_i);
         n = n + 1;
      end
      check({tag, "_drained"}, 32'(exp_r.size() + exp_b.size() + exp_acc.size()), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      #2 rst_i = 1'b1;
      #1;
      check("rst_ready", {29'd0, s_axil_arready_o, s_axil_awready_o, s_axil_wready_o}, 32'd0);
      check("rst_valid", {29'd0, s_axil_rvalid_o, s_axil_bvalid_o, reg_req_o}, 32'd0);
      check("rst_data", s_axil_rdata_o | reg_wdata_o | {16'd0, reg_addr_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(posedge clk_i); #1;

      // Zero-wait read with latency measurement.
      tb_rdata = 32'hCAFE_0001; req_cycles = 0;
      exp_acc.push_back('{1'b0, 16'h0010, 32'h0});
      exp_r.push_back('{32'hCAFE_0001, 2'b00});
      drive(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0, 32'h0);
      wait_drained("rd1");
      check("rd1_latency", 32'(rv_rise_cyc - ar_hs_cyc), 32'd3);
      check("rd1_req_cycles", 32'(req_cycles), 32'd1);

      // W arrives two cycles before AW.
      exp_acc.push_back('{1'b1, 16'h0020, 32'h1234_5678});
      exp_b.push_back('{32'h0, 2'b00});
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'h1234_5678);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("wready_held", {31'd0, s_axil_wready_o}, 32'd0);
      @(posedge clk_i); #1;
      drive(1'b0, 16'h0, 1'b1, 16'h0020, 1'b0, 32'h0);
      wait_drained("wr_w_first");

      // Contended read/write, twice: read first, then write first.
      tb_rdata = 32'hA5A5_0004;
      exp_acc.push_back('{1'b0, 16'h0004, 32'h0});
      exp_acc.push_back('{1'b1, 16'h0008, 32'h0BAD_F00D});
      exp_r.push_back('{32'hA5A5_0004, 2'b00});
      exp_b.push_back('{32'h0, 2'b00});
      drive(1'b1, 16'h0004, 1'b1, 16'h0008, 1'b1, 32'h0BAD_F00D);
      wait_drained("rr_round1");
      exp_acc.push_back('{1'b1, 16'h0008, 32'h600D_0002});
      exp_acc.push_back('{1'b0, 16'h0004, 32'h0});
      exp_r.push_back('{32'hA5A5_0004, 2'b00});
      exp_b.push_back('{32'h0, 2'b00});
      drive(1'b1, 16'h0004, 1'b1, 16'h0008, 1'b1, 32'h600D_0002);
      wait_drained("rr_round2");

      // Downstream error on a read.
      tb_err = 1'b1; tb_rdata = 32'h0000_0E0E;
      exp_acc.push_back('{1'b0, 16'h0014, 32'h0});
      exp_r.push_back('{32'h0000_0E0E, 2'b10});
      drive(1'b1, 16'h0014, 1'b0, 16'h0, 1'b0, 32'h0);
      wait_drained("rd_err");
      tb_err = 1'b0;

      // Timeout: request held exactly four cycles, then late ready ignored.
      auto_ready = 1'b0; req_cycles = 0;
      exp_r.push_back('{32'hDEAD_BEEF, 2'b10});
      drive(1'b1, 16'h0030, 1'b0, 16'h0, 1'b0, 32'h0);
      wait_drained("rd_timeout");
      check("timeout_req_cycles", 32'(req_cycles), 32'd4);
      force_ready = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("late_ready_ignored", {29'd0, reg_req_o, s_axil_rvalid_o, s_axil_bvalid_o}, 32'd0);
      @(posedge clk_i); #1;
      force_ready = 1'b0; auto_ready = 1'b1;

      // Misaligned write then aligned write.
      req_cycles = 0;
      exp_b.push_back('{32'h0, 2'b10});
      drive(1'b0, 16'h0, 1'b1, 16'h0006, 1'b1, 32'h7777_7777);
      wait_drained("wr_misaligned");
      check("misaligned_no_req", 32'(req_cycles), 32'd0);
      exp_acc.push_back('{1'b1, 16'h000C, 32'h5555_AAAA});
      exp_b.push_back('{32'h0, 2'b00});
      drive(1'b0, 16'h0, 1'b1, 16'h000C, 1'b1, 32'h5555_AAAA);
      wait_drained("wr_aligned");

      // Reset during RD_ACC with rready low.
      auto_ready = 1'b0; s_axil_rready_i = 1'b0;
      drive(1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 32'h0);
      for (int i = 0; i < 20 && !reg_req_o; i++) @(posedge clk_i);
      check("rst_test_in_acc", {31'd0, reg_req_o}, 32'd1);
      @(posedge clk_i); #2;
      rst_i = 1'b1;
      #1;
      check("async_rst_req", {29'd0, reg_req_o, reg_we_o, s_axil_rvalid_o}, 32'd0);
      check("async_rst_addr", {16'd0, reg_addr_o}, 32'd0);
      check("async_rst_ready", {29'd0, s_axil_arready_o, s_axil_awready_o, s_axil_wready_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("no_stale_rvalid", {30'd0, s_axil_rvalid_o, reg_req_o}, 32'd0);
      @(posedge clk_i); #1;
      auto_ready = 1'b1; s_axil_rready_i = 1'b1; tb_rdata = 32'h0000_4444;
      exp_acc.push_back('{1'b0, 16'h0044, 32'h0});
      exp_r.push_back('{32'h0000_4444, 2'b00});
      drive(1'b1, 16'h0044, 1'b0, 16'h0, 1'b0, 32'h0);
      wait_drained("rd_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
